video_timing: RTL and testbench

Single-clock raster timing generator for the 480x272 RGB LCD panel, running on the LCD pixel clock. It replaces the separate horizontal/vertical counter pair and the per-signal delay stages. It produces pixel coordinates for the sprite/pixel stage and pipeline-delayed HSYNC/VSYNC/DEN aligned to that stage's output. It also emits a one-cycle frame tick, so frame counters need not clock off VSYNC.

---
 rtl/lcd_timing_pkg.sv | 31 +++
 rtl/video_timing_if.sv | 23 ++
 rtl/pipe_delay.sv | 37 +++
 rtl/video_timing.sv | 110 +++++++++++
 tb/tb_video_timing.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_timing_pkg.sv
// Panel timing constants and shared types for the 480x272 LCD raster generator.
// Counter and coordinate widths are fixed by the panel geometry.
package lcd_timing_pkg;

    localparam int LCD_H_ACTIVE = 480;
    localparam int LCD_H_FRONT  = 8;
    localparam int LCD_H_SYNC   = 4;
    localparam int LCD_H_BACK   = 43;
    localparam int LCD_H_TOTAL  = LCD_H_ACTIVE + LCD_H_FRONT
                                + LCD_H_SYNC + LCD_H_BACK;

    localparam int LCD_V_ACTIVE = 272;
    localparam int LCD_V_FRONT  = 8;
    localparam int LCD_V_SYNC   = 4;
    localparam int LCD_V_BACK   = 12;
    localparam int LCD_V_TOTAL  = LCD_V_ACTIVE + LCD_V_FRONT
                                + LCD_V_SYNC + LCD_V_BACK;

    localparam int X_W = 9;
    localparam int Y_W = 9;
    localparam int H_W = 10;
    localparam int V_W = 9;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        logic tick;
    } sync_t;

endpackage

// File: rtl/video_timing_if.sv
// Raster timing bundle from the timing generator to the pixel stage.
// The generator drives it; consumers see every signal as input.
interface video_timing_if;
    import lcd_timing_pkg::*;

    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           hde;
    logic           vde;
    logic           hsync;
    logic           vsync;
    logic           de;
    logic           frame_tick;

    modport master (
        output x, y, hde, vde, hsync, vsync, de, frame_tick
    );

    modport slave (
        input x, y, hde, vde, hsync, vsync, de, frame_tick
    );

endinterface

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with async active-low reset.
// DEPTH = 0 is a plain wire so the caller need not special-case it.
module pipe_delay #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign q = d;
    end else begin : g_chain
        logic [WIDTH-1:0] sr [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    sr[i] <= RESET_VAL;
                end
            end else begin
                sr[0] <= d;
                for (int i = 1; i < DEPTH; i++) begin
                    sr[i] <= sr[i-1];
                end
            end
        end

        assign q = sr[DEPTH-1];
    end

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: h/v counters, undelayed coordinates and enables,
// and pipeline-aligned sync/de/frame-tick for the pixel stage output.
module video_timing
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE        = LCD_H_ACTIVE,
    parameter int H_FRONT         = LCD_H_FRONT,
    parameter int H_SYNC          = LCD_H_SYNC,
    parameter int H_BACK          = LCD_H_BACK,
    parameter int V_ACTIVE        = LCD_V_ACTIVE,
    parameter int V_FRONT         = LCD_V_FRONT,
    parameter int V_SYNC          = LCD_V_SYNC,
    parameter int V_BACK          = LCD_V_BACK,
    parameter int PIPE_DELAY      = 2,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_hde,
    output logic           o_vde,
    output logic           o_hsync,
    output logic           o_vsync,
    output logic           o_de,
    output logic           o_frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_BEG  = H_ACTIVE + H_FRONT;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FRONT;
    localparam int VS_END  = VS_BEG + V_SYNC;

    localparam logic  IDLE     = (SYNC_ACTIVE_LOW != 0);
    localparam sync_t SYNC_RST = '{hsync: IDLE, vsync: IDLE,
                                   de: 1'b0, tick: 1'b0};

    if (H_TOTAL > 1024) begin : g_h_chk
        $error("video_timing: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 512) begin : g_v_chk
        $error("video_timing: V_TOTAL exceeds 512");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_d_chk
        $error("video_timing: PIPE_DELAY outside 0..7");
    end

    logic [H_W-1:0] hcnt;
    logic [V_W-1:0] vcnt;
    logic           h_wrap;
    logic           v_wrap;

    assign h_wrap = int'(hcnt) == H_TOTAL - 1;
    assign v_wrap = int'(vcnt) == V_TOTAL - 1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            hcnt <= h_wrap ? '0 : hcnt + 1'b1;
            if (h_wrap) begin
                vcnt <= v_wrap ? '0 : vcnt + 1'b1;
            end
        end
    end

    logic  hde;
    logic  vde;
    logic  hs_on;
    logic  vs_on;
    sync_t sync_d;
    sync_t sync_q;

    // vcnt only moves on the hcnt wrap, so vsync spans whole lines
    always_comb begin
        hde   = int'(hcnt) < H_ACTIVE;
        vde   = int'(vcnt) < V_ACTIVE;
        hs_on = (int'(hcnt) >= HS_BEG) && (int'(hcnt) < HS_END);
        vs_on = (int'(vcnt) >= VS_BEG) && (int'(vcnt) < VS_END);
        sync_d       = SYNC_RST;
        sync_d.hsync = hs_on ^ IDLE;
        sync_d.vsync = vs_on ^ IDLE;
        sync_d.de    = hde & vde;
        sync_d.tick  = (hcnt == '0) && (vcnt == '0);
    end

    pipe_delay #(
        .WIDTH     ($bits(sync_t)),
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL (SYNC_RST)
    ) u_pipe (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .d     (sync_d),
        .q     (sync_q)
    );

    assign o_x          = hde ? hcnt[X_W-1:0] : '0;
    assign o_y          = vde ? vcnt : '0;
    assign o_hde        = hde;
    assign o_vde        = vde;
    assign o_hsync      = sync_q.hsync;
    assign o_vsync      = sync_q.vsync;
    assign o_de         = sync_q.de;
    assign o_frame_tick = sync_q.tick;

endmodule

// File: tb/tb_video_timing.sv
// Directed bench for video_timing: default panel timing at delay 0 and 2,
// active-high polarity, and a shrunk raster for whole-frame checks.
module tb_video_timing;
    import lcd_timing_pkg::*;

    localparam int DHT = 535, DVT = 296;
    localparam int DHSB = 488, DHSE = 492;
    localparam int SHT = 24, SVT = 12, SHA = 16, SVA = 6;
    localparam int SHSB = 18, SHSE = 21, SVSB = 8, SVSE = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    logic [8:0] u0_x, u0_y, up_x, up_y, us_x, us_y;
    logic u0_hde, u0_vde, u0_hs, u0_vs, u0_de, u0_tick;
    logic up_hde, up_vde, up_hs, up_vs, up_de, up_tick;
    logic us_hde, us_vde, us_hs, us_vs, us_de, us_tick;

    video_timing_if vif();

    video_timing #(.PIPE_DELAY(0)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .o_x(u0_x), .o_y(u0_y),
        .o_hde(u0_hde), .o_vde(u0_vde), .o_hsync(u0_hs),
        .o_vsync(u0_vs), .o_de(u0_de), .o_frame_tick(u0_tick)
    );

    video_timing #(.PIPE_DELAY(2)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .o_x(vif.x), .o_y(vif.y),
        .o_hde(vif.hde), .o_vde(vif.vde), .o_hsync(vif.hsync),
        .o_vsync(vif.vsync), .o_de(vif.de),
        .o_frame_tick(vif.frame_tick)
    );

    video_timing #(.PIPE_DELAY(0), .SYNC_ACTIVE_LOW(0)) up (
        .i_clk(clk), .i_rst_n(rst_n), .o_x(up_x), .o_y(up_y),
        .o_hde(up_hde), .o_vde(up_vde), .o_hsync(up_hs),
        .o_vsync(up_vs), .o_de(up_de), .o_frame_tick(up_tick)
    );

    video_timing #(
        .H_ACTIVE(SHA), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(SVA), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
        .PIPE_DELAY(2)
    ) us (
        .i_clk(clk), .i_rst_n(rst_n), .o_x(us_x), .o_y(us_y),
        .o_hde(us_hde), .o_vde(us_vde), .o_hsync(us_hs),
        .o_vsync(us_vs), .o_de(us_de), .o_frame_tick(us_tick)
    );

    function automatic bit m_hs(int k, int ht, int b, int e);
        int h;
        h = k % ht;
        return (h >= b) && (h < e);
    endfunction

    function automatic bit m_vs(int k, int ht, int vt, int b, int e);
        int v;
        v = (k / ht) % vt;
        return (v >= b) && (v < e);
    endfunction

    function automatic bit m_de(int k, int ht, int vt, int ha, int va);
        return ((k % ht) < ha) && (((k / ht) % vt) < va);
    endfunction

    function automatic bit m_tick(int k, int ht, int vt);
        return (k % (ht * vt)) == 0;
    endfunction

    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            vectors++;
            if ({vif.hsync, vif.vsync, vif.de, vif.frame_tick,
                 vif.x, vif.y} !== {4'b1100, 18'd0}) begin
                miscompares++;
                $display("FAIL reset_d2 cyc=%0d got %h exp %h", i,
                    {vif.hsync, vif.vsync, vif.de, vif.frame_tick,
                     vif.x, vif.y}, {4'b1100, 18'd0});
            end
            vectors++;
            if ({u0_x, u0_y, u0_hde, u0_vde} !== {18'd0, 2'b11}) begin
                miscompares++;
                $display("FAIL reset_d0 cyc=%0d got %h exp %h", i,
                    {u0_x, u0_y, u0_hde, u0_vde}, {18'd0, 2'b11});
            end
            vectors++;
            if ({up_hs, up_vs, us_hs, us_vs, us_de, us_tick}
                !== 6'b001100) begin
                miscompares++;
                $display("FAIL reset_pol cyc=%0d got %b exp 001100", i,
                    {up_hs, up_vs, us_hs, us_vs, us_de, us_tick});
            end
        end
    endtask

    task automatic test_line();
        int h, v, hi, lo, hs_lo, hde_rise, de_rise;
        logic p_hde, p_de, e_hde;
        logic [23:0] e0, ep, e2;
        hi = 0; lo = 0; hs_lo = 0; hde_rise = -1; de_rise = -1;
        p_hde = 1'b1; p_de = 1'b0;
        release_rst();
        for (int k = 0; k < 2 * DHT; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            h = k % DHT;
            v = k / DHT;
            e_hde = h < 480;
            e0 = {e_hde, 1'b1, 9'(e_hde ? h : 0), 9'(v),
                  ~m_hs(k, DHT, DHSB, DHSE), 1'b1,
                  m_tick(k, DHT, DVT), e_hde};
            ep = {e_hde, 1'b1, 9'(e_hde ? h : 0), 9'(v),
                  m_hs(k, DHT, DHSB, DHSE), 1'b0,
                  m_tick(k, DHT, DVT), e_hde};
            e2 = {e_hde, 1'b1, 9'(e_hde ? h : 0), 9'(v), 4'b1100};
            if (k >= 2) begin
                e2[3:0] = {~m_hs(k - 2, DHT, DHSB, DHSE), 1'b1,
                           m_de(k - 2, DHT, DVT, 480, 272),
                           m_tick(k - 2, DHT, DVT)};
            end
            vectors++;
            if ({u0_hde, u0_vde, u0_x, u0_y, u0_hs, u0_vs, u0_tick,
                 u0_de} !== e0) begin
                miscompares++;
                $display("FAIL line_d0 k=%0d got %h exp %h", k,
                    {u0_hde, u0_vde, u0_x, u0_y, u0_hs, u0_vs, u0_tick,
                     u0_de}, e0);
            end
            vectors++;
            if ({up_hde, up_vde, up_x, up_y, up_hs, up_vs, up_tick,
                 up_de} !== ep) begin
                miscompares++;
                $display("FAIL line_pol k=%0d got %h exp %h", k,
                    {up_hde, up_vde, up_x, up_y, up_hs, up_vs, up_tick,
                     up_de}, ep);
            end
            vectors++;
            if ({vif.hde, vif.vde, vif.x, vif.y, vif.hsync, vif.vsync,
                 vif.de, vif.frame_tick} !== e2) begin
                miscompares++;
                $display("FAIL line_d2 k=%0d got %h exp %h", k,
                    {vif.hde, vif.vde, vif.x, vif.y, vif.hsync,
                     vif.vsync, vif.de, vif.frame_tick}, e2);
            end
            if (k >= DHT) begin
                if (u0_hde) hi++; else lo++;
                if (!u0_hs) hs_lo++;
                if (u0_hde && !p_hde && hde_rise < 0) hde_rise = k;
                if (vif.de && !p_de && de_rise < 0) de_rise = k;
            end
            p_hde = u0_hde;
            p_de  = vif.de;
        end
        vectors++;
        if ({hi, lo, hs_lo} !== {32'd480, 32'd55, 32'd4}) begin
            miscompares++;
            $display("FAIL line_runs got hde_hi=%0d hde_lo=%0d hs_lo=%0d exp 480 55 4",
                hi, lo, hs_lo);
        end
        vectors++;
        if (hde_rise !== DHT || de_rise !== DHT + 2) begin
            miscompares++;
            $display("FAIL de_align got hde_rise=%0d de_rise=%0d exp %0d %0d",
                hde_rise, de_rise, DHT, DHT + 2);
        end
    endtask

    task automatic test_frame();
        int h, v, t0, t1, vs_start, vs_len;
        logic e_hde, e_vde;
        logic [19:0] eu;
        logic [3:0]  ed;
        t0 = -1; t1 = -1; vs_start = -1; vs_len = 0;
        pulse_rst();
        for (int k = 0; k <= 600; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            h = k % SHT;
            v = (k / SHT) % SVT;
            e_hde = h < SHA;
            e_vde = v < SVA;
            eu = {e_hde, e_vde, 9'(e_hde ? h : 0), 9'(e_vde ? v : 0)};
            ed = 4'b1100;
            if (k >= 2) begin
                ed = {~m_hs(k - 2, SHT, SHSB, SHSE),
                      ~m_vs(k - 2, SHT, SVT, SVSB, SVSE),
                      m_de(k - 2, SHT, SVT, SHA, SVA),
                      m_tick(k - 2, SHT, SVT)};
            end
            vectors++;
            if ({us_hde, us_vde, us_x, us_y} !== eu) begin
                miscompares++;
                $display("FAIL frame_xy k=%0d got %h exp %h", k,
                    {us_hde, us_vde, us_x, us_y}, eu);
            end
            vectors++;
            if ({us_hs, us_vs, us_de, us_tick} !== ed) begin
                miscompares++;
                $display("FAIL frame_sync k=%0d got %b exp %b", k,
                    {us_hs, us_vs, us_de, us_tick}, ed);
            end
            if (us_tick) begin
                if (t0 < 0) t0 = k;
                else if (t1 < 0) t1 = k;
            end
            if (!us_vs && k < 290) begin
                if (vs_start < 0) vs_start = k;
                vs_len++;
            end
        end
        vectors++;
        if (t0 !== 2 || t1 - t0 !== SHT * SVT) begin
            miscompares++;
            $display("FAIL frame_period got t0=%0d period=%0d exp 2 %0d",
                t0, t1 - t0, SHT * SVT);
        end
        vectors++;
        if (vs_start !== SVSB * SHT + 2 || vs_len !== 2 * SHT) begin
            miscompares++;
            $display("FAIL vsync_window got start=%0d len=%0d exp %0d %0d",
                vs_start, vs_len, SVSB * SHT + 2, 2 * SHT);
        end
    endtask

    task automatic test_midframe_reset();
        logic [2:0] es;
        logic [1:0] e2;
        pulse_rst();
        repeat (82) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({us_hs, us_vs, us_de, us_tick, us_x, us_y}
            !== {4'b1100, 18'd0}) begin
            miscompares++;
            $display("FAIL async_rst_small got %h exp %h",
                {us_hs, us_vs, us_de, us_tick, us_x, us_y},
                {4'b1100, 18'd0});
        end
        vectors++;
        if ({vif.hsync, vif.vsync, vif.de, vif.frame_tick, vif.x, vif.y}
            !== {4'b1100, 18'd0}) begin
            miscompares++;
            $display("FAIL async_rst_d2 got %h exp %h",
                {vif.hsync, vif.vsync, vif.de, vif.frame_tick,
                 vif.x, vif.y}, {4'b1100, 18'd0});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 30; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            es = 3'b100;
            e2 = 2'b10;
            if (k >= 2) begin
                es = {~m_hs(k - 2, SHT, SHSB, SHSE),
                      m_de(k - 2, SHT, SVT, SHA, SVA),
                      m_tick(k - 2, SHT, SVT)};
                e2 = {~m_hs(k - 2, DHT, DHSB, DHSE),
                      m_tick(k - 2, DHT, DVT)};
            end
            vectors++;
            if ({us_hs, us_de, us_tick} !== es) begin
                miscompares++;
                $display("FAIL restart_small k=%0d got %b exp %b", k,
                    {us_hs, us_de, us_tick}, es);
            end
            vectors++;
            if ({vif.hsync, vif.frame_tick} !== e2) begin
                miscompares++;
                $display("FAIL restart_d2 k=%0d got %b exp %b", k,
                    {vif.hsync, vif.frame_tick}, e2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==",
            vectors, miscompares);
        $finish;
    end

endmodule
